// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode-stage definitions: hazard FSM states, the x0 index and
// default register-file geometry. Also imported by the decode/GPR blocks.
package id_hazard_ctrl_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard bus.
//   master : decode/writeback side; drives id_* and wb_*, observes controls.
//   slave  : hazard controller; consumes id_*/wb_*, drives issue, stall_ifid,
//            bubble_idex, flush_ifid, pending, sb_err.
interface id_hazard_ctrl_if
  import id_hazard_ctrl_pkg::*;
#(
  parameter int NumRegs  = NUM_REGS,
  parameter int RegAddrW = REG_ADDR_W
);
  logic                id_valid;
  logic [RegAddrW-1:0] id_rs1n;
  logic [RegAddrW-1:0] id_rs2n;
  logic [RegAddrW-1:0] id_rdn;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic                id_wr_rd;
  logic                id_branch_taken;
  logic                wb_valid;
  logic [RegAddrW-1:0] wb_rdn;
  logic                issue;
  logic                stall_ifid;
  logic                bubble_idex;
  logic                flush_ifid;
  logic [NumRegs-1:0]  pending;
  logic                sb_err;

  modport master (
    output id_valid, id_rs1n, id_rs2n, id_rdn, id_use_rs1, id_use_rs2,
           id_wr_rd, id_branch_taken, wb_valid, wb_rdn,
    input  issue, stall_ifid, bubble_idex, flush_ifid, pending, sb_err
  );

  modport slave (
    input  id_valid, id_rs1n, id_rs2n, id_rdn, id_use_rs1, id_use_rs2,
           id_wr_rd, id_branch_taken, wb_valid, wb_rdn,
    output issue, stall_ifid, bubble_idex, flush_ifid, pending, sb_err
  );
endinterface

// File: rtl/id_hazard_ctrl_sb_counter_bank.sv
// sb_counter_bank: one saturating in-flight write counter per GPR.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   inc, inc_rdn      issuing writer (caller already excludes x0)
//   dec, dec_rdn      writeback retire; ignored when the counter is 0
//   rs1n/rs2n/rdn     lookup indices -> cnt_rs1/cnt_rs2/cnt_rd
//   cnt_wb            counter of dec_rdn (for underflow detection)
//   pending           bit r = counter r non-zero
module sb_counter_bank #(
  parameter int NumRegs     = 32,
  parameter int RegAddrW    = 5,
  parameter int MaxInflight = 3,
  parameter int CntW        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic [RegAddrW-1:0] inc_rdn,
  input  logic                dec,
  input  logic [RegAddrW-1:0] dec_rdn,
  input  logic [RegAddrW-1:0] rs1n,
  input  logic [RegAddrW-1:0] rs2n,
  input  logic [RegAddrW-1:0] rdn,
  output logic [CntW-1:0]     cnt_rs1,
  output logic [CntW-1:0]     cnt_rs2,
  output logic [CntW-1:0]     cnt_rd,
  output logic [CntW-1:0]     cnt_wb,
  output logic [NumRegs-1:0]  pending
);
  localparam logic [CntW-1:0] CNT_MAX = CntW'(MaxInflight);

  logic [NumRegs-1:0][CntW-1:0] cnt, cnt_nxt;

  // x0 is hardwired; it never accumulates in-flight writes.
  assign cnt_nxt[0] = '0;
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < NumRegs; r++) begin : g_reg
    logic inc_hit, dec_hit;
    assign inc_hit = inc & (inc_rdn == RegAddrW'(r)) & (cnt[r] != CNT_MAX);
    assign dec_hit = dec & (dec_rdn == RegAddrW'(r)) & (cnt[r] != '0);
    // inc and dec on the same register cancel.
    assign cnt_nxt[r] = (inc_hit & ~dec_hit) ? cnt[r] + 1'b1 :
                        (dec_hit & ~inc_hit) ? cnt[r] - 1'b1 : cnt[r];
    assign pending[r] = |cnt[r];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  assign cnt_rs1 = cnt[rs1n];
  assign cnt_rs2 = cnt[rs2n];
  assign cnt_rd  = cnt[rdn];
  assign cnt_wb  = cnt[dec_rdn];
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: scoreboard sequencer for the decode stage. Decides each
// cycle whether the IF/ID instruction issues, stalls (bubble into ID/EX) or
// is squashed after a taken branch; tracks in-flight GPR writes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        slave side of id_hazard_ctrl_if (decode/writeback inputs,
//              issue/stall/bubble/flush controls, pending vector, sb_err)
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int NumRegs     = NUM_REGS,
  parameter int RegAddrW    = REG_ADDR_W,
  parameter int MaxInflight = 3,
  parameter int FlushCycles = 1
) (
  input logic              clk,
  input logic              rst,
  id_hazard_ctrl_if.slave  bus
);
  localparam int CntW  = $clog2(MaxInflight + 1);
  localparam int FcntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
  localparam logic [CntW-1:0] CNT_MAX = CntW'(MaxInflight);

  hz_state_t         state, state_nxt;
  logic [FcntW-1:0]  fcnt, fcnt_nxt;
  logic [CntW-1:0]   cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic              raw_hz, waw_hz, hazard;
  logic              issue_c, stall_c, bubble_c, flush_c;
  logic              issue, inc, sb_err;
  logic [NumRegs-1:0] pending;

  sb_counter_bank #(
    .NumRegs(NumRegs), .RegAddrW(RegAddrW),
    .MaxInflight(MaxInflight), .CntW(CntW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .inc_rdn (bus.id_rdn),
    .dec     (bus.wb_valid),
    .dec_rdn (bus.wb_rdn),
    .rs1n    (bus.id_rs1n),
    .rs2n    (bus.id_rs2n),
    .rdn     (bus.id_rdn),
    .cnt_rs1 (cnt_rs1),
    .cnt_rs2 (cnt_rs2),
    .cnt_rd  (cnt_rd),
    .cnt_wb  (cnt_wb),
    .pending (pending)
  );

  // No writeback bypass: a RAW clears only once the counter itself is 0.
  assign raw_hz = (bus.id_use_rs1 & (bus.id_rs1n != REG_ZERO) & (cnt_rs1 != '0)) |
                  (bus.id_use_rs2 & (bus.id_rs2n != REG_ZERO) & (cnt_rs2 != '0));
  assign waw_hz = bus.id_wr_rd & (bus.id_rdn != REG_ZERO) & (cnt_rd == CNT_MAX);
  assign hazard = bus.id_valid & (raw_hz | waw_hz);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    issue_c   = 1'b0;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    case (state)
      RUN, STALL: begin
        issue_c  = bus.id_valid & ~hazard;
        stall_c  = hazard;
        bubble_c = hazard;
        if (issue_c & bus.id_branch_taken) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FcntW'(FlushCycles - 1);
        end else if (hazard) begin
          state_nxt = STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        // IF/ID content is wrong-path; id_* is ignored entirely.
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (fcnt == '0) state_nxt = RUN;
        else            fcnt_nxt  = fcnt - 1'b1;
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = '0;
      end
    endcase
  end

  // Controls are held quiet while reset is asserted.
  assign issue = issue_c & ~rst;
  assign inc   = issue & bus.id_wr_rd & (bus.id_rdn != REG_ZERO);

  // Writeback to an idle register is a scoreboard underflow; make it sticky.
  always_ff @(posedge clk) begin
    if (rst)
      sb_err <= 1'b0;
    else if (bus.wb_valid & (bus.wb_rdn != REG_ZERO) & (cnt_wb == '0))
      sb_err <= 1'b1;
  end

  assign bus.issue       = issue;
  assign bus.stall_ifid  = stall_c  & ~rst;
  assign bus.bubble_idex = bubble_c & ~rst;
  assign bus.flush_ifid  = flush_c  & ~rst;
  assign bus.pending     = rst ? '0 : pending;
  assign bus.sb_err      = sb_err & ~rst;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.NumRegs(32), .RegAddrW(5)) bus ();

  id_hazard_ctrl #(
    .NumRegs(32), .RegAddrW(5), .MaxInflight(3), .FlushCycles(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic wr, input logic br);
    bus.id_valid = v; bus.id_rs1n = rs1; bus.id_rs2n = rs2; bus.id_rdn = rd;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_wr_rd = wr;
    bus.id_branch_taken = br;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rdn);
    bus.wb_valid = v; bus.wb_rdn = rdn;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0);
  endtask

  task automatic test_reset();
    idle();
    bus.id_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({bus.issue, bus.stall_ifid, bus.bubble_idex, bus.flush_ifid} !== 4'b0) begin
        failures++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.issue, bus.stall_ifid, bus.bubble_idex, bus.flush_ifid}); end
      tick();
    end
    rst = 1'b0;
    idle();
    #1;
    checks++; if ({bus.issue, bus.stall_ifid, bus.bubble_idex, bus.flush_ifid, bus.sb_err} !== 5'b0) begin
      failures++; $display("FAIL post_reset_ctrl got=%b exp=00000", {bus.issue, bus.stall_ifid, bus.bubble_idex, bus.flush_ifid, bus.sb_err}); end
    checks++; if (bus.pending !== 32'h0) begin
      failures++; $display("FAIL post_reset_pending got=%h exp=0", bus.pending); end
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.issue !== 1'b1 || bus.stall_ifid !== 1'b0 || bus.pending !== 32'h0) begin
        failures++; $display("FAIL idle_issue[%0d] got issue=%b stall=%b pend=%h exp issue=1 stall=0 pend=0", i, bus.issue, bus.stall_ifid, bus.pending); end
      tick();
    end
    idle();
  endtask

  task automatic test_raw();
    // cycle 1: writer of x5
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    checks++; if (bus.issue !== 1'b1) begin failures++; $display("FAIL raw_c1_issue got=%b exp=1", bus.issue); end
    tick();
    // cycles 2-4: reader of x5 stalls; writeback on cycle 4 is not bypassed
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) set_wb(1'b1, 5'd5);
      #1;
      checks++; if ({bus.issue, bus.stall_ifid, bus.bubble_idex} !== 3'b011) begin
        failures++; $display("FAIL raw_c%0d_stall got=%b exp=011", c, {bus.issue, bus.stall_ifid, bus.bubble_idex}); end
      checks++; if (bus.pending[5] !== 1'b1) begin failures++; $display("FAIL raw_c%0d_pend5 got=%b exp=1", c, bus.pending[5]); end
      tick();
    end
    set_wb(1'b0, 5'd0); #1;
    checks++; if ({bus.issue, bus.stall_ifid, bus.bubble_idex} !== 3'b100) begin
      failures++; $display("FAIL raw_c5_issue got=%b exp=100", {bus.issue, bus.stall_ifid, bus.bubble_idex}); end
    checks++; if (bus.pending[5] !== 1'b0) begin failures++; $display("FAIL raw_c5_pend5 got=%b exp=0", bus.pending[5]); end
    tick();
    // rs2 hazard, and an unused rs1 naming a busy register does not stall
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++; if (bus.issue !== 1'b1) begin failures++; $display("FAIL raw_unused_rs1 got=%b exp=1", bus.issue); end
    set_id(1'b1, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (bus.stall_ifid !== 1'b1) begin failures++; $display("FAIL raw_rs2_stall got=%b exp=1", bus.stall_ifid); end
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd6); tick();
    idle();
  endtask

  task automatic test_branch();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if ({bus.issue, bus.flush_ifid} !== 2'b10) begin
      failures++; $display("FAIL br_issue got=%b exp=10", {bus.issue, bus.flush_ifid}); end
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if ({bus.flush_ifid, bus.issue, bus.stall_ifid, bus.bubble_idex} !== 4'b1001) begin
        failures++; $display("FAIL br_flush%0d got=%b exp=1001", c, {bus.flush_ifid, bus.issue, bus.stall_ifid, bus.bubble_idex}); end
      tick();
    end
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++; if ({bus.flush_ifid, bus.issue, bus.bubble_idex} !== 3'b010) begin
      failures++; $display("FAIL br_back_to_run got=%b exp=010", {bus.flush_ifid, bus.issue, bus.bubble_idex}); end
    tick();
    idle();
  endtask

  task automatic test_saturation();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (bus.issue !== 1'b1) begin failures++; $display("FAIL sat_w%0d_issue got=%b exp=1", c, bus.issue); end
      tick();
    end
    #1;
    checks++; if ({bus.issue, bus.stall_ifid} !== 2'b01) begin
      failures++; $display("FAIL sat_w4_stall got=%b exp=01", {bus.issue, bus.stall_ifid}); end
    tick();
    set_wb(1'b1, 5'd7); #1;
    checks++; if ({bus.issue, bus.stall_ifid} !== 2'b01) begin
      failures++; $display("FAIL sat_wb_cycle got=%b exp=01", {bus.issue, bus.stall_ifid}); end
    tick();
    set_wb(1'b0, 5'd0); #1;
    checks++; if ({bus.issue, bus.stall_ifid} !== 2'b10) begin
      failures++; $display("FAIL sat_w4_issue got=%b exp=10", {bus.issue, bus.stall_ifid}); end
    tick();
    // count must be back at 3: three retires to drain x7
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd7);
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      checks++; if (bus.pending[7] !== (k < 3)) begin
        failures++; $display("FAIL sat_drain%0d_pend7 got=%b exp=%b", k, bus.pending[7], (k < 3)); end
    end
    idle(); #1;
    checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL sat_no_err got=%b exp=0", bus.sb_err); end
  endtask

  task automatic test_inc_dec();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    set_wb(1'b1, 5'd9); #1;
    checks++; if ({bus.issue, bus.stall_ifid} !== 2'b10) begin
      failures++; $display("FAIL incdec_issue got=%b exp=10", {bus.issue, bus.stall_ifid}); end
    tick();
    idle(); #1;
    checks++; if (bus.pending[9] !== 1'b1) begin failures++; $display("FAIL incdec_pend9 got=%b exp=1", bus.pending[9]); end
    set_wb(1'b1, 5'd9); tick();
    set_wb(1'b0, 5'd0); #1;
    checks++; if ({bus.pending[9], bus.sb_err} !== 2'b00) begin
      failures++; $display("FAIL incdec_drain got pend9,err=%b exp=00", {bus.pending[9], bus.sb_err}); end
  endtask

  task automatic test_x0();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    set_wb(1'b1, 5'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({bus.issue, bus.stall_ifid, bus.pending[0], bus.sb_err} !== 4'b1000) begin
        failures++; $display("FAIL x0_c%0d got=%b exp=1000", c, {bus.issue, bus.stall_ifid, bus.pending[0], bus.sb_err}); end
      tick();
    end
    idle();
  endtask

  task automatic test_sb_err();
    set_wb(1'b1, 5'd12); tick();
    set_wb(1'b0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({bus.sb_err, bus.pending[12]} !== 2'b10) begin
        failures++; $display("FAIL sberr_hold%0d got=%b exp=10", c, {bus.sb_err, bus.pending[12]}); end
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL sberr_clear got=%b exp=0", bus.sb_err); end
  endtask

  task automatic test_reset_abort();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    idle(); #1;
    checks++; if ({bus.flush_ifid, bus.pending[3]} !== 2'b11) begin
      failures++; $display("FAIL abort_pre got=%b exp=11", {bus.flush_ifid, bus.pending[3]}); end
    rst = 1'b1; #1;
    checks++; if ({bus.flush_ifid, bus.bubble_idex, bus.pending[3]} !== 3'b000) begin
      failures++; $display("FAIL abort_during got=%b exp=000", {bus.flush_ifid, bus.bubble_idex, bus.pending[3]}); end
    tick();
    rst = 1'b0;
    set_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++; if ({bus.issue, bus.stall_ifid, bus.flush_ifid} !== 3'b100 || bus.pending !== 32'h0) begin
      failures++; $display("FAIL abort_after got=%b pend=%h exp=100 pend=0", {bus.issue, bus.stall_ifid, bus.flush_ifid}, bus.pending); end
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_branch();
    test_saturation();
    test_inc_dec();
    test_x0();
    test_sb_err();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Scoreboard-based sequencer for the decode stage: IF/ID latch, GPR read ports, branch address calculation.
- Tracks in-flight GPR writes and decides each cycle whether the decoded instruction issues, stalls in IF/ID (bubble into ID/EX), or is squashed after a taken branch.
- Sits beside the decode stage; drives the IF/ID hold/flush and ID/EX bubble controls.

Parameters:
- NumRegs, 32, number of architectural GPRs; x0 is never tracked.
- RegAddrW, 5, register index width; must equal log2(NumRegs).
- MaxInflight, 3, max outstanding writes per register; counter width is clog2(MaxInflight+1).
- FlushCycles, 1, cycles IF/ID is flushed after a taken branch; must be ≥1.

Ports:
- clk, input, 1, pipeline clock.
- rst, input, 1, synchronous active-high reset.
- id_valid, input, 1, IF/ID holds a valid instruction.
- id_rs1n, input, RegAddrW, source 1 index.
- id_rs2n, input, RegAddrW, source 2 index.
- id_rdn, input, RegAddrW, destination index.
- id_use_rs1, input, 1, instruction reads rs1.
- id_use_rs2, input, 1, instruction reads rs2.
- id_wr_rd, input, 1, instruction writes rd.
- id_branch_taken, input, 1, branch resolved taken in ID.
- wb_valid, input, 1, writeback retires a GPR write this cycle (same as GPR wbe).
- wb_rdn, input, RegAddrW, writeback destination.
- issue, output, 1, instruction leaves ID this cycle.
- stall_ifid, output, 1, hold PC and IF/ID latch.
- bubble_idex, output, 1, load NOP into ID/EX.
- flush_ifid, output, 1, squash IF/ID contents.
- pending, output, NumRegs, bit r set when cnt[r] is not 0; bit 0 always 0.
- sb_err, output, 1, sticky: writeback to a register with cnt 0.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all cnt = 0, state = RUN, flush counter = 0, sb_err = 0. During and after reset: issue=0, stall_ifid=0, bubble_idex=0, flush_ifid=0, pending=0.
- raw_hz = (id_use_rs1 & rs1n≠0 & cnt[rs1n]≠0) | (id_use_rs2 & rs2n≠0 & cnt[rs2n]≠0).
  - No same-cycle writeback bypass. The hazard clears the cycle after the counter reaches 0.
- waw_hz = id_wr_rd & rdn≠0 & cnt[rdn]==MaxInflight.
- hazard = id_valid & (raw_hz | waw_hz).
- FSM states RUN, STALL, FLUSH.
  - RUN:
    - issue = id_valid & ~hazard.
    - stall_ifid = bubble_idex = hazard.
    - If issue & id_branch_taken: go to FLUSH, flush counter = FlushCycles-1.
    - Else if hazard: go to STALL.
  - STALL: outputs are the same functions as in RUN. When hazard drops, issue=1 that same cycle and the FSM goes to RUN, or to FLUSH if the issuing instruction is a taken branch.
  - FLUSH:
    - flush_ifid=1, issue=0, stall_ifid=0, bubble_idex=1.
    - id_* inputs ignored; id_branch_taken ignored.
    - Counter decrements each cycle; at 0 go to RUN next cycle.
- All outputs are combinational from registered state/counters plus current inputs. flush_ifid depends on state only.
- id_branch_taken is honoured only on an issuing cycle.
- Counter update per cycle:
  - inc = issue & id_wr_rd & rdn≠0.
  - dec = wb_valid & wb_rdn≠0 & cnt[wb_rdn]≠0.
  - Same register inc and dec: net unchanged.
  - Different registers: both applied.
- wb_valid with cnt[wb_rdn]==0 and wb_rdn≠0: counter unchanged, sb_err set until reset.
- Writebacks are processed in every state, including STALL and FLUSH.
- Reset mid-stall or mid-flush: aborts immediately to the reset values above. No in-flight accounting survives reset.

Decomposition:
- Shared package, already used by decode/GPR blocks:
  - hz_state_t enum {RUN, STALL, FLUSH}.
  - REG_ZERO constant.
  - Default NumRegs/RegAddrW values.
- One natural sub-module, sb_counter_bank: NumRegs saturating up/down counters, returning cnt lookups for rs1/rs2/rd and the pending vector.
- FSM and hazard logic stay in id_hazard_ctrl.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0; id_valid=1, no uses → issue=1 every cycle, pending=0.
- RAW stall:
  - Stimulus: issue writer of x5; next cycle reader of x5 (use_rs1, rs1n=5); wb_valid, wb_rdn=5 on cycle 4.
  - Required: stall_ifid=bubble_idex=1 on cycles 2–4, issue=1 on cycle 5, pending[5] 1→0 after cycle 4.
- Taken branch with FlushCycles=2: branch issues with id_branch_taken=1 → flush_ifid=1 for exactly 2 cycles, issue=0 there even with id_valid=1, then RUN.
- Saturation:
  - Stimulus: four back-to-back writers of x7 with no writeback.
  - Required: first three issue (cnt=3); fourth stalls; wb_rdn=7 → fourth issues next cycle, cnt stays 3.
- Simultaneous inc/dec on x9 with cnt=1: issue writer of x9 while wb_rdn=9 → cnt stays 1, pending[9]=1, no stall for a writer.
- Errors and x0:
  - wb_valid with wb_rdn=12 and cnt 0 → sb_err=1 and held until rst.
  - Writers/readers of x0 → never stall, pending[0]=0.
